// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target (and the I2C_master rewrite).
//   i2c_tgt_state_t   - target FSM state encoding
//   I2C_BITS_PER_BYTE - data bits in one I2C byte, excluding the ACK slot
//   I2C_RW_WRITE/READ - R/W bit encoding in the address byte
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX,
        ST_ACK_RX,
        ST_TX,
        ST_WAIT_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam int   I2C_BITS_PER_BYTE = 8;
    localparam logic I2C_RW_WRITE      = 1'b0;
    localparam logic I2C_RW_READ       = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings scl/sda into the clk domain and derives bus events.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   scl, sda       - raw I2C line levels (asynchronous to clk)
//   sda_level      - synchronised SDA, aligned with the strobes below
//   scl_rise/fall  - one-cycle SCL edge strobes
//   start_det      - one-cycle strobe: SDA fell while SCL high
//   stop_det       - one-cycle strobe: SDA rose while SCL high
// Every output is registered, so a line edge shows up as a strobe 3 clk later.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Synchroniser flops reset to 1 to match an idle, pulled-up bus so that
    // leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_h     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_h     <= 1'b1;
            sda_level <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_s1    <= scl;
            scl_s2    <= scl_s1;
            scl_h     <= scl_s2;
            sda_s1    <= sda;
            sda_s2    <= sda_s1;
            sda_h     <= sda_s2;
            sda_level <= sda_s2;
            scl_rise  <= scl_s2 & ~scl_h;
            scl_fall  <= ~scl_s2 & scl_h;
            // SCL must be high both before and after the SDA edge.
            start_det <= scl_s2 & scl_h & sda_h & ~sda_s2;
            stop_det  <= scl_s2 & scl_h & ~sda_h & sda_s2;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// i2c_target: single-address I2C target, open-drain SDA, no clock stretching.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   scl       - I2C clock from the master (input only)
//   sda       - I2C data, driven 0 or released (z)
//   tx_data   - byte returned on a read, captured while tx_load is high
//   tx_load   - one-cycle pulse when tx_data is captured
//   rx_data   - last byte written by the master
//   rx_valid  - one-cycle pulse, the cycle after rx_data updates
//   busy      - high from the matched-address ACK until STOP/START
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_BYTE);

    i2c_tgt_state_t state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift;
    logic           sda_low;
    logic           rw;
    logic           ack_bit;
    logic           rx_pend;

    logic sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda = sda_low ? 1'b0 : 1'bz;

    // Bus events override everything else, including a same-cycle SCL strobe.
    // In TX, shift[7] is the bit currently on the bus and bit_cnt counts the
    // bits already presented; the shift register is loaded in the cycle
    // tx_load is high so tx_data only has to be valid during that pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'd0;
            sda_low  <= 1'b0;
            rw       <= I2C_RW_WRITE;
            ack_bit  <= 1'b1;
            rx_pend  <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= rx_pend;
            rx_pend  <= 1'b0;
            tx_load  <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det && state != ST_IDLE) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_level};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == ADDR) begin
                                state   <= ST_ACK_ADDR;
                                sda_low <= 1'b1;
                                busy    <= 1'b1;
                                rw      <= shift[0];
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ACK_ADDR: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= 4'd0;
                            if (rw == I2C_RW_READ) begin
                                tx_load <= 1'b1;
                                state   <= ST_TX;
                            end else begin
                                state <= ST_RX;
                            end
                        end
                    end
                    ST_RX: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_level};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT - 4'd1) begin
                                rx_data <= {shift[6:0], sda_level};
                                rx_pend <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            sda_low <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= ST_ACK_RX;
                        end
                    end
                    ST_ACK_RX: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            state   <= ST_RX;
                        end
                    end
                    ST_TX: begin
                        if (tx_load) begin
                            shift   <= tx_data;
                            sda_low <= ~tx_data[7];
                            bit_cnt <= 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                sda_low <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_WAIT_ACK;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_low <= ~shift[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (scl_rise) begin
                            ack_bit <= sda_level;
                        end else if (scl_fall) begin
                            if (!ack_bit) begin
                                tx_load <= 1'b1;
                                state   <= ST_TX;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                        // IDLE and IGNORE only leave on START/STOP.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target. A bit-banged master drives
// scl and pulls sda low through a pull-up; every bit is setup-low, high,
// hold-low with phases far longer than the target's sampling latency.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h3C;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    wire        sda;

    int pass_cnt = 0;
    int check_cnt = 0;
    int rx_valid_cnt = 0;
    int tx_load_cnt = 0;
    int drive_cnt = 0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_target #(.ADDR(7'h1A)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse and drive monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) rx_valid_cnt++;
        if (tx_load) tx_load_cnt++;
        if (!m_low && sda === 1'b0) drive_cnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic applyStimulus(input logic scl_v, input logic low_v, input int n);
        scl   = scl_v;
        m_low = low_v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic drive_low, output logic seen);
        applyStimulus(1'b0, drive_low, H);
        applyStimulus(1'b1, drive_low, H / 2);
        seen = sda;
        applyStimulus(1'b1, drive_low, H / 2);
        applyStimulus(1'b0, drive_low, H / 2);
    endtask

    task automatic bus_start();
        applyStimulus(1'b1, 1'b0, H);
        applyStimulus(1'b1, 1'b1, H);
        applyStimulus(1'b0, 1'b1, H / 2);
    endtask

    task automatic bus_rstart();
        applyStimulus(1'b0, 1'b0, H);
        applyStimulus(1'b1, 1'b0, H);
        applyStimulus(1'b1, 1'b1, H);
        applyStimulus(1'b0, 1'b1, H / 2);
    endtask

    task automatic bus_stop();
        applyStimulus(1'b0, 1'b1, H);
        applyStimulus(1'b1, 1'b1, H);
        applyStimulus(1'b1, 1'b0, H);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic seen;
        for (int i = 7; i >= 0; i--) clock_bit(!d[i], seen);
        clock_bit(1'b0, ack);
    endtask

    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                             output logic [7:0] d, output int loads_before_ack);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b0, seen);
            d[i] = seen;
        end
        loads_before_ack = tx_load_cnt;
        tx_data = next_tx;
        clock_bit(master_ack, seen);
    endtask

    initial begin
        logic       ack;
        logic       seen;
        logic [7:0] d;
        int         rv0, tl0, dr0, lb;

        repeat (4) @(negedge clk);
        checkOutput("reset_sda", 32'(sda), 32'd1);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_tx_load", 32'(tx_load), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write 0xA5 to 0x1A.
        rv0 = rx_valid_cnt;
        bus_start();
        send_byte(8'h34, ack);
        checkOutput("wr_addr_ack", 32'(ack), 32'd0);
        checkOutput("wr_busy", 32'(busy), 32'd1);
        send_byte(8'hA5, ack);
        checkOutput("wr_data_ack", 32'(ack), 32'd0);
        checkOutput("wr_rx_data", 32'(rx_data), 32'hA5);
        checkOutput("wr_rx_valid_cnt", 32'(rx_valid_cnt - rv0), 32'd1);
        checkOutput("wr_busy_before_stop", 32'(busy), 32'd1);
        bus_stop();
        checkOutput("wr_busy_after_stop", 32'(busy), 32'd0);
        checkOutput("wr_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // Address 0x1B: never acknowledged, never driven.
        rv0 = rx_valid_cnt;
        dr0 = drive_cnt;
        bus_start();
        send_byte(8'h36, ack);
        checkOutput("nm_addr_nack", 32'(ack), 32'd1);
        checkOutput("nm_state_ignore", 32'(dut.state), 32'(ST_IGNORE));
        send_byte(8'h00, ack);
        checkOutput("nm_data_nack", 32'(ack), 32'd1);
        checkOutput("nm_state_ignore2", 32'(dut.state), 32'(ST_IGNORE));
        checkOutput("nm_no_drive", 32'(drive_cnt - dr0), 32'd0);
        checkOutput("nm_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
        checkOutput("nm_busy", 32'(busy), 32'd0);
        bus_stop();
        checkOutput("nm_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // Read one byte (0x3C), master NACK.
        tx_data = 8'h3C;
        tl0 = tx_load_cnt;
        bus_start();
        send_byte(8'h35, ack);
        checkOutput("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, 8'h3C, d, lb);
        checkOutput("rd_byte", 32'(d), 32'h3C);
        checkOutput("rd_tx_load_cnt", 32'(tx_load_cnt - tl0), 32'd1);
        checkOutput("rd_sda_released", 32'(sda), 32'd1);
        checkOutput("rd_state_ignore", 32'(dut.state), 32'(ST_IGNORE));
        bus_stop();
        checkOutput("rd_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // Read two bytes: 0x3C with master ACK, then 0xC3 with NACK.
        tx_data = 8'h3C;
        tl0 = tx_load_cnt;
        bus_start();
        send_byte(8'h35, ack);
        checkOutput("rd2_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, 8'hC3, d, lb);
        checkOutput("rd2_byte0", 32'(d), 32'h3C);
        checkOutput("rd2_loads_before_ack", 32'(lb - tl0), 32'd1);
        checkOutput("rd2_loads_after_ack", 32'(tx_load_cnt - tl0), 32'd2);
        read_byte(1'b0, 8'h00, d, lb);
        checkOutput("rd2_byte1", 32'(d), 32'hC3);
        checkOutput("rd2_tx_load_total", 32'(tx_load_cnt - tl0), 32'd2);
        checkOutput("rd2_busy", 32'(busy), 32'd1);
        bus_stop();
        checkOutput("rd2_busy_after_stop", 32'(busy), 32'd0);

        // Repeated START after 4 data bits, then write 0x5A.
        rv0 = rx_valid_cnt;
        bus_start();
        send_byte(8'h34, ack);
        checkOutput("rs_addr_ack", 32'(ack), 32'd0);
        clock_bit(1'b0, seen);
        clock_bit(1'b1, seen);
        clock_bit(1'b0, seen);
        clock_bit(1'b1, seen);
        bus_rstart();
        checkOutput("rs_partial_no_valid", 32'(rx_valid_cnt - rv0), 32'd0);
        checkOutput("rs_state_addr", 32'(dut.state), 32'(ST_ADDR));
        send_byte(8'h34, ack);
        checkOutput("rs_addr2_ack", 32'(ack), 32'd0);
        send_byte(8'h5A, ack);
        checkOutput("rs_data_ack", 32'(ack), 32'd0);
        checkOutput("rs_rx_data", 32'(rx_data), 32'h5A);
        checkOutput("rs_rx_valid_cnt", 32'(rx_valid_cnt - rv0), 32'd1);
        bus_stop();

        // Reset while the address ACK is being driven.
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'h34;
            clock_bit(!d[i], seen);
        end
        applyStimulus(1'b0, 1'b0, H);
        applyStimulus(1'b1, 1'b0, H / 2);
        checkOutput("rst_ack_driven", 32'(sda), 32'd0);
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_sda_released", 32'(sda), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'h00);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_tx_load", 32'(tx_load), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, H / 2);
        applyStimulus(1'b0, 1'b0, H / 2);
        bus_stop();
        rv0 = rx_valid_cnt;
        bus_start();
        send_byte(8'h34, ack);
        checkOutput("post_rst_addr_ack", 32'(ack), 32'd0);
        send_byte(8'hC6, ack);
        checkOutput("post_rst_data_ack", 32'(ack), 32'd0);
        checkOutput("post_rst_rx_data", 32'(rx_data), 32'hC6);
        checkOutput("post_rst_rx_valid_cnt", 32'(rx_valid_cnt - rv0), 32'd1);
        bus_stop();
        checkOutput("post_rst_idle", 32'(dut.state), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
